// File: rtl/mpe_window_sequencer.sv
// mpe_window_sequencer
// Walks a K_H x K_W kernel over a latched input tile. For every kernel tap it
// gathers an OUT_H x OUT_W output tile using the latched stride and dilation.
// Source positions outside the input tile read as zero.
// Taps are emitted in raster order through a valid/ready handshake.
// After the last tap the block reports completion with a one-cycle done pulse.
module mpe_window_sequencer #(
    parameter int BIN_LEN = 16,
    parameter int IN_H    = 8,
    parameter int IN_W    = 8,
    parameter int OUT_H   = 4,
    parameter int OUT_W   = 4,
    parameter int K_H     = 3,
    parameter int K_W     = 3
) (
    input  logic                             clock,
    input  logic                             reset_n,
    input  logic                             start,
    input  logic [IN_H*IN_W*BIN_LEN-1:0]     in_vals,
    input  logic [2:0]                       stride,
    input  logic [1:0]                       dilation,
    input  logic                             out_ready,
    output logic                             out_valid,
    output logic [OUT_H*OUT_W*BIN_LEN-1:0]   out_vals,
    output logic [$clog2(K_H)-1:0]           out_kh,
    output logic [$clog2(K_W)-1:0]           out_kw,
    output logic                             out_last,
    output logic                             busy,
    output logic                             done,
    output logic                             err
);

    localparam int KH_W = $clog2(K_H);
    localparam int KW_W = $clog2(K_W);
    localparam int IN_BITS  = IN_H * IN_W * BIN_LEN;
    localparam int OUT_BITS = OUT_H * OUT_W * BIN_LEN;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state;

    // Sweep context captured when start is accepted
    logic [IN_BITS-1:0]  in_reg;
    logic [2:0]          stride_reg;
    logic [1:0]          dil_reg;

    // Decoded control
    logic [1:0]          d_eff;
    logic                accept;
    logic                reject;
    logic                advance;
    logic                at_last_tap;

    // Tap and source context for the output tile loaded at the next edge
    logic [KH_W-1:0]     next_kh;
    logic [KW_W-1:0]     next_kw;
    logic [IN_BITS-1:0]  src_tile;
    logic [2:0]          src_stride;
    logic [1:0]          src_dil;
    logic [OUT_BITS-1:0] gathered;
    int                  row;
    int                  col;

    // Decode start handling, handshake and end-of-sweep conditions
    always_comb begin
        d_eff       = (dilation == 2'd0) ? 2'd1 : dilation;
        accept      = (state == IDLE) && start && (stride != 3'd0);
        reject      = (state == IDLE) && start && (stride == 3'd0);
        advance     = (state == EMIT) && out_ready;
        at_last_tap = (out_kh == KH_W'(K_H - 1)) && (out_kw == KW_W'(K_W - 1));
    end

    // Choose the tap to load next: (0,0) on acceptance, otherwise the raster successor
    always_comb begin
        next_kh = '0;
        next_kw = '0;
        if (state != IDLE) begin
            if (out_kw == KW_W'(K_W - 1)) begin
                next_kw = '0;
                next_kh = out_kh + KH_W'(1);
            end else begin
                next_kw = out_kw + KW_W'(1);
                next_kh = out_kh;
            end
        end
    end

    // On acceptance the context registers are still loading, so gather straight from the ports
    always_comb begin
        if (state == IDLE) begin
            src_tile   = in_vals;
            src_stride = stride;
            src_dil    = d_eff;
        end else begin
            src_tile   = in_reg;
            src_stride = stride_reg;
            src_dil    = dil_reg;
        end
    end

    // Gather one output tile for the next tap; out-of-range sources read as zero
    always_comb begin
        gathered = '0;
        row      = 0;
        col      = 0;
        for (int i = 0; i < OUT_H; i++) begin
            for (int j = 0; j < OUT_W; j++) begin
                row = i * int'(src_stride) + int'(next_kh) * int'(src_dil);
                col = j * int'(src_stride) + int'(next_kw) * int'(src_dil);
                if (row < IN_H && col < IN_W) begin
                    gathered[(i*OUT_W + j)*BIN_LEN +: BIN_LEN] =
                        src_tile[(row*IN_W + col)*BIN_LEN +: BIN_LEN];
                end
            end
        end
    end

    // Sequencer FSM with registered outputs and latched sweep context
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            in_reg     <= '0;
            stride_reg <= '0;
            dil_reg    <= '0;
            out_valid  <= 1'b0;
            out_vals   <= '0;
            out_kh     <= '0;
            out_kw     <= '0;
            out_last   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    err  <= 1'b0;
                    if (accept) begin
                        state      <= EMIT;
                        in_reg     <= in_vals;
                        stride_reg <= stride;
                        dil_reg    <= d_eff;
                        out_valid  <= 1'b1;
                        out_vals   <= gathered;
                        out_kh     <= '0;
                        out_kw     <= '0;
                        out_last   <= (K_H == 1) && (K_W == 1);
                        busy       <= 1'b1;
                    end else if (reject) begin
                        state <= DONE;
                        busy  <= 1'b1;
                        done  <= 1'b1;
                        err   <= 1'b1;
                    end
                end

                EMIT: begin
                    if (advance) begin
                        if (at_last_tap) begin
                            state     <= DONE;
                            out_valid <= 1'b0;
                            out_vals  <= '0;
                            out_kh    <= '0;
                            out_kw    <= '0;
                            out_last  <= 1'b0;
                            done      <= 1'b1;
                            err       <= 1'b0;
                        end else begin
                            out_vals <= gathered;
                            out_kh   <= next_kh;
                            out_kw   <= next_kw;
                            out_last <= (next_kh == KH_W'(K_H - 1)) &&
                                        (next_kw == KW_W'(K_W - 1));
                        end
                    end
                end

                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    err   <= 1'b0;
                end

                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    err       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mpe_window_sequencer.sv
// tb_mpe_window_sequencer
// Directed scenarios for the window sequencer: reset, basic sweep, stride with
// padding, dilation, backpressure, error/ignore, and reset mid-sweep.
module tb_mpe_window_sequencer;

    logic         clock;
    logic         reset_n;
    logic         start;
    logic [1023:0] in_vals;
    logic [2:0]   stride;
    logic [1:0]   dilation;
    logic         out_ready;
    logic         out_valid;
    logic [255:0] out_vals;
    logic [1:0]   out_kh;
    logic [1:0]   out_kw;
    logic         out_last;
    logic         busy;
    logic         done;
    logic         err;

    int checks = 0;
    int errors = 0;
    int hs_count = 0;
    logic [255:0] tap_vals [9];

    mpe_window_sequencer dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (start),
        .in_vals   (in_vals),
        .stride    (stride),
        .dilation  (dilation),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_vals  (out_vals),
        .out_kh    (out_kh),
        .out_kw    (out_kw),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    // Free-running clock
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Count accepted output handshakes
    always @(posedge clock) begin
        if (out_valid && out_ready) hs_count <= hs_count + 1;
    end

    // Element of an output tile
    function automatic logic [15:0] get_elem(input logic [255:0] v, input int i, input int j);
        return v[(i*4 + j)*16 +: 16];
    endfunction

    // Expected element for the in[r][c] = r*8+c pattern with zero padding
    function automatic logic [15:0] model_elem(input int i, input int j, input int kh,
                                               input int kw, input int s, input int d);
        int r;
        int c;
        r = i*s + kh*d;
        c = j*s + kw*d;
        if (r < 8 && c < 8) return 16'(r*8 + c);
        return 16'd0;
    endfunction

    // Expected output tile for one tap
    function automatic logic [255:0] model_tile(input int kh, input int kw, input int s, input int d);
        logic [255:0] v;
        v = '0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                v[(i*4 + j)*16 +: 16] = model_elem(i, j, kh, kw, s, d);
        return v;
    endfunction

    // Load the ramp pattern, pulse start, then scramble the inputs
    task automatic launch(input logic [2:0] s, input logic [1:0] d);
        @(negedge clock);
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                in_vals[(r*8 + c)*16 +: 16] = 16'(r*8 + c);
        stride   = s;
        dilation = d;
        start    = 1'b1;
        @(negedge clock);
        start    = 1'b0;
        in_vals  = {64{16'hBEEF}};
        stride   = 3'd5;
        dilation = 2'd3;
    endtask

    // Check all nine taps and the done cycle of a sweep launched just before
    task automatic sweep_check(input int s, input int d, input int pulse_tap, input string name);
        logic [255:0] exp_v;
        for (int t = 0; t < 9; t++) begin
            exp_v = model_tile(t / 3, t % 3, s, d);
            tap_vals[t] = out_vals;
            checks++;
            if (out_valid !== 1'b1 || out_kh !== 2'(t / 3) || out_kw !== 2'(t % 3) ||
                out_last !== (t == 8) || out_vals !== exp_v) begin
                errors++;
                $display("[TB] FAIL %s tap%0d: got valid=%b kh=%0d kw=%0d last=%b vals=%h, expected kh=%0d kw=%0d last=%b vals=%h",
                         name, t, out_valid, out_kh, out_kw, out_last, out_vals,
                         t / 3, t % 3, (t == 8), exp_v);
            end
            if (t == pulse_tap) begin
                start  = 1'b1;
                stride = 3'd3;
            end
            @(negedge clock);
            start = 1'b0;
        end
        checks++;
        if (done !== 1'b1 || err !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s done_cycle: got done=%b err=%b valid=%b busy=%b, expected 1 0 0 1",
                     name, done, err, out_valid, busy);
        end
        @(negedge clock);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s idle_return: got done=%b busy=%b valid=%b, expected 0 0 0",
                     name, done, busy, out_valid);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #12;
        checks++;
        if (out_valid !== 1'b0 || out_vals !== 256'd0 || out_kh !== 2'd0 || out_kw !== 2'd0 ||
            out_last !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_state: got valid=%b vals=%h kh=%0d kw=%0d last=%b busy=%b done=%b err=%b, expected all zero",
                     out_valid, out_vals, out_kh, out_kw, out_last, busy, done, err);
        end
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_basic();
        launch(3'd1, 2'd1);
        sweep_check(1, 1, -1, "basic");
        checks++;
        if (get_elem(tap_vals[0], 0, 0) !== 16'd0 || get_elem(tap_vals[8], 3, 3) !== 16'd45) begin
            errors++;
            $display("[TB] FAIL basic_corners: got tap0[0][0]=%0d tap8[3][3]=%0d, expected 0 and 45",
                     get_elem(tap_vals[0], 0, 0), get_elem(tap_vals[8], 3, 3));
        end
    endtask

    task automatic test_stride_padding();
        launch(3'd2, 2'd1);
        sweep_check(2, 1, -1, "stride2");
        checks++;
        if (get_elem(tap_vals[8], 3, 3) !== 16'd0 || get_elem(tap_vals[8], 2, 2) !== 16'd54) begin
            errors++;
            $display("[TB] FAIL stride2_padding: got [3][3]=%0d [2][2]=%0d, expected 0 and 54",
                     get_elem(tap_vals[8], 3, 3), get_elem(tap_vals[8], 2, 2));
        end
    endtask

    task automatic test_dilation();
        launch(3'd1, 2'd2);
        sweep_check(1, 2, -1, "dil2");
        checks++;
        if (get_elem(tap_vals[4], 0, 0) !== 16'd18) begin
            errors++;
            $display("[TB] FAIL dil2_tap11: got %0d, expected 18", get_elem(tap_vals[4], 0, 0));
        end
        launch(3'd1, 2'd0);
        sweep_check(1, 1, -1, "dil0");
    endtask

    task automatic test_backpressure();
        logic [255:0] hold;
        int base;
        int cyc;
        base = hs_count;
        launch(3'd1, 2'd1);
        for (int t = 0; t < 3; t++) @(negedge clock);
        checks++;
        if (out_valid !== 1'b1 || out_kh !== 2'd1 || out_kw !== 2'd0 || out_vals !== model_tile(1, 0, 1, 1)) begin
            errors++;
            $display("[TB] FAIL bp_tap10: got valid=%b kh=%0d kw=%0d vals=%h, expected tap (1,0) vals=%h",
                     out_valid, out_kh, out_kw, out_vals, model_tile(1, 0, 1, 1));
        end
        hold = out_vals;
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            checks++;
            if (out_valid !== 1'b1 || out_kh !== 2'd1 || out_kw !== 2'd0 || out_last !== 1'b0 || out_vals !== hold) begin
                errors++;
                $display("[TB] FAIL bp_hold%0d: got valid=%b kh=%0d kw=%0d last=%b vals=%h, expected held tap (1,0) vals=%h",
                         k, out_valid, out_kh, out_kw, out_last, out_vals, hold);
            end
        end
        out_ready = 1'b1;
        @(negedge clock);
        checks++;
        if (out_valid !== 1'b1 || out_kh !== 2'd1 || out_kw !== 2'd1 || out_vals !== model_tile(1, 1, 1, 1)) begin
            errors++;
            $display("[TB] FAIL bp_resume: got valid=%b kh=%0d kw=%0d vals=%h, expected tap (1,1) vals=%h",
                     out_valid, out_kh, out_kw, out_vals, model_tile(1, 1, 1, 1));
        end
        cyc = 0;
        while (done !== 1'b1 && cyc < 20) begin
            @(negedge clock);
            cyc++;
        end
        checks++;
        if (done !== 1'b1 || hs_count - base !== 9) begin
            errors++;
            $display("[TB] FAIL bp_total: got done=%b handshakes=%0d, expected done=1 handshakes=9",
                     done, hs_count - base);
        end
        @(negedge clock);
    endtask

    task automatic test_error_ignore();
        @(negedge clock);
        stride = 3'd0;
        start  = 1'b1;
        @(negedge clock);
        start  = 1'b0;
        checks++;
        if (done !== 1'b1 || err !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL stride0_done: got done=%b err=%b valid=%b busy=%b, expected 1 1 0 1",
                     done, err, out_valid, busy);
        end
        @(negedge clock);
        checks++;
        if (done !== 1'b0 || err !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stride0_idle: got done=%b err=%b valid=%b busy=%b, expected all 0",
                     done, err, out_valid, busy);
        end
        launch(3'd1, 2'd1);
        sweep_check(1, 1, 2, "start_ignored");
    endtask

    task automatic test_reset_mid_sweep();
        launch(3'd1, 2'd1);
        for (int t = 0; t < 5; t++) @(negedge clock);
        checks++;
        if (out_kh !== 2'd1 || out_kw !== 2'd2 || out_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mid_tap12: got valid=%b kh=%0d kw=%0d, expected 1 1 2",
                     out_valid, out_kh, out_kw);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_vals !== 256'd0 || out_kh !== 2'd0 || out_kw !== 2'd0 ||
            out_last !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_reset: got valid=%b vals=%h kh=%0d kw=%0d last=%b busy=%b done=%b err=%b, expected all zero",
                     out_valid, out_vals, out_kh, out_kw, out_last, busy, done, err);
        end
        @(negedge clock);
        reset_n = 1'b1;
        launch(3'd1, 2'd1);
        sweep_check(1, 1, -1, "after_reset");
    endtask

    // Scenario sequence
    initial begin
        reset_n   = 1'b0;
        start     = 1'b0;
        in_vals   = '0;
        stride    = 3'd1;
        dilation  = 2'd1;
        out_ready = 1'b1;
        test_reset();
        test_basic();
        test_stride_padding();
        test_dilation();
        test_backpressure();
        test_error_ignore();
        test_reset_mid_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mpe_window_sequencer.md
MPE_WINDOW_SEQUENCER -- requirements
Module: mpe_window_sequencer

Interface
REQ-001 Parameters SHALL be:
- BIN_LEN, 16, element width in bits
- IN_H, 8, input tile height
- IN_W, 8, input tile width
- OUT_H, 4, output tile height
- OUT_W, 4, output tile width
- K_H, 3, kernel height
- K_W, 3, kernel width
REQ-002 Clocking SHALL be one clock; reset SHALL be asynchronous and active-low.
REQ-003 Ports SHALL be:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  begin one sweep; accepted only in IDLE
- in_vals  in  IN_H*IN_W*BIN_LEN  input tile, row-major, element [r][c] at bit offset (r*IN_W+c)*BIN_LEN
- stride  in  3  window step, sampled at start
- dilation  in  2  kernel-tap spacing, sampled at start; 0 treated as 1
- out_ready  in  1  consumer accepts current output
- out_valid  out  1  out_vals/out_kh/out_kw/out_last valid
- out_vals  out  OUT_H*OUT_W*BIN_LEN  gathered tile, row-major, same packing as in_vals
- out_kh  out  clog2(K_H)  kernel row of the current output
- out_kw  out  clog2(K_W)  kernel column of the current output
- out_last  out  1  current output is tap (K_H-1, K_W-1)
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at sweep end
- err  out  1  valid with done; sweep aborted

Function
REQ-004 FSM states SHALL be IDLE, EMIT and DONE.
REQ-005 IDLE with start=1 and stride!=0 SHALL, in one clock:
- latch in_vals, stride, and effective dilation d into internal registers
- set kh=kw=0
- enter EMIT
REQ-006 IDLE with start=1 and stride==0 SHALL enter DONE with err=1 and produce no outputs.
REQ-007 In EMIT, out_valid SHALL be 1 and out_vals[i][j] SHALL equal latched in[i*stride + kh*d][j*stride + kw*d].
REQ-008 Any element whose source row >= IN_H or source column >= IN_W SHALL read as zero (zero padding, no wrap).
REQ-009 Index arithmetic SHALL be wide enough that no intermediate value overflows.
REQ-010 out_vals SHALL be registered; first valid output SHALL appear the cycle after start is accepted (latency 1).
REQ-011 out_valid=1 with out_ready=0 SHALL hold all out_* signals stable.
REQ-012 out_valid=1 with out_ready=1 SHALL advance the tap in raster order: kw+1; at kw=K_W-1, kw=0 and kh+1.
REQ-013 Outputs SHALL be produced one per cycle under continuous ready, with no bubbles.
REQ-014 Handshake on the tap with out_last=1 SHALL enter DONE.
REQ-015 DONE SHALL last exactly one cycle, assert done=1 (err=0 for a normal sweep), then return to IDLE.
REQ-016 start SHALL be ignored in EMIT and DONE.
REQ-017 Changes to in_vals, stride or dilation after start is accepted SHALL NOT affect the sweep in progress.
REQ-018 out_valid SHALL remain 0 in IDLE and DONE.

Reset
REQ-019 reset_n=0 SHALL, asynchronously and at any point including mid-sweep:
- force IDLE
- drive out_valid, out_vals, out_kh, out_kw, out_last, busy, done and err to 0
- clear all latched registers
REQ-020 After reset_n deasserts, the first sweep SHALL be accepted on the first start.

Verification
REQ-021 Basic sweep: defaults, in[r][c]=r*8+c, stride=1, dilation=1, ready=1, start → 9 outputs on consecutive cycles; tap (0,0) out[0][0]=0; tap (2,2) out[3][3]=45; out_last only on the 9th; done 1 cycle later.
REQ-022 Stride and padding: stride=2, dilation=1 → tap (2,2) out[3][3]=in[8][8] → 0 (padding); out[2][2]=in[6][6]=54.
REQ-023 Dilation: stride=1, dilation=2 → tap (1,1) out[0][0]=in[2][2]=18; dilation=0 SHALL produce results identical to dilation=1.
REQ-024 Backpressure: ready held 0 for 3 cycles at tap (1,0) → outputs stable for those cycles; sweep resumes at (1,1) on ready=1; total handshakes=9.
REQ-025 Error and ignore: start with stride=0 → done=1 and err=1 next cycle, no out_valid; start pulsed during EMIT → no restart, tap sequence unchanged.
REQ-026 Reset mid-sweep: reset_n=0 at tap (1,2) → all outputs 0 immediately; after release, a new start produces a full 9-tap sweep from (0,0).
